// File: rtl/divide_by_3_fsm.sv
// Divide-by-3 Moore FSM: y is high for one clk cycle in every three.
// Define DIV3_ONEHOT_EN to use one-hot state codes instead of binary.
`timescale 1ns/1ps

module divide_by_3_fsm (
  input  logic       clk,
  input  logic       reset,
  output logic       y,
  output logic [2:0] state,
  output logic [2:0] nextstate
);

`ifdef DIV3_ONEHOT_EN
  localparam logic [2:0] S0 = 3'b001;
  localparam logic [2:0] S1 = 3'b010;
  localparam logic [2:0] S2 = 3'b100;
`else
  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S0;
    else       state <= nextstate;
  end

  // Any code outside S0..S2 falls back to S0, so a corrupted state
  // recovers on the next edge.
  always_comb begin
    nextstate = S0;
    case (state)
      S0:      nextstate = S1;
      S1:      nextstate = S2;
      S2:      nextstate = S0;
      default: nextstate = S0;
    endcase
  end

  assign y = (state == S0);

endmodule

// File: tb/tb_divide_by_3_fsm.sv
// Bench for divide_by_3_fsm: reset, free-running cycle, async reset in S2,
// and recovery from an illegal state code. Works in both encodings.
`timescale 1ns/1ps

module tb_divide_by_3_fsm;

`ifdef DIV3_ONEHOT_EN
  localparam logic [2:0] S0 = 3'b001;
  localparam logic [2:0] S1 = 3'b010;
  localparam logic [2:0] S2 = 3'b100;
`else
  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
`endif
  localparam logic [2:0] BAD = 3'b101;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       y;
  logic [2:0] state;
  logic [2:0] nextstate;

  always #5 clk = ~clk;

  divide_by_3_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .y         (y),
    .state     (state),
    .nextstate (nextstate)
  );

  typedef struct {
    logic       rst;
    logic [2:0] st;
    logic       yv;
    logic [2:0] ns;
  } vec_t;

  // scoreboard: {state, y, nextstate}
  logic [6:0] exp_q[$];
  int asserts = 0;
  int fails   = 0;

  task automatic push_exp(input logic [2:0] st, input logic yv, input logic [2:0] ns);
    exp_q.push_back({st, yv, ns});
  endtask

  task automatic check(input string name, input bit chk_state);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      asserts++;
      fails++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_q.pop_front();
    if (chk_state) begin
      asserts++;
      if (state !== e[6:4]) begin
        fails++;
        $display("FAIL %s state: got %b expected %b at %0t", name, state, e[6:4], $time);
      end
    end
    asserts++;
    if (y !== e[3]) begin
      fails++;
      $display("FAIL %s y: got %b expected %b at %0t", name, y, e[3], $time);
    end
    asserts++;
    if (nextstate !== e[2:0]) begin
      fails++;
      $display("FAIL %s nextstate: got %b expected %b at %0t", name, nextstate, e[2:0], $time);
    end
  endtask

  // watchdog
  initial begin
    #5000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "timeout");
  end

  vec_t run_tbl[10];
  vec_t restart_tbl[3];

  initial begin
    // after release: edges at 15..105 ns; y high at 35, 65, 95 ns
    run_tbl[0] = '{1'b0, S1, 1'b0, S2};
    run_tbl[1] = '{1'b0, S2, 1'b0, S0};
    run_tbl[2] = '{1'b0, S0, 1'b1, S1};
    run_tbl[3] = '{1'b0, S1, 1'b0, S2};
    run_tbl[4] = '{1'b0, S2, 1'b0, S0};
    run_tbl[5] = '{1'b0, S0, 1'b1, S1};
    run_tbl[6] = '{1'b0, S1, 1'b0, S2};
    run_tbl[7] = '{1'b0, S2, 1'b0, S0};
    run_tbl[8] = '{1'b0, S0, 1'b1, S1};
    run_tbl[9] = '{1'b0, S1, 1'b0, S2};
    restart_tbl[0] = '{1'b0, S1, 1'b0, S2};
    restart_tbl[1] = '{1'b0, S2, 1'b0, S0};
    restart_tbl[2] = '{1'b0, S0, 1'b1, S1};

    // reset held 0..12 ns, including the 5 ns edge
    #1;
    push_exp(S0, 1'b1, S1);
    check("reset_t1", 1'b1);
    @(posedge clk); #1;
    push_exp(S0, 1'b1, S1);
    check("reset_edge5", 1'b1);
    #6;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      push_exp(run_tbl[i].st, run_tbl[i].yv, run_tbl[i].ns);
      reset = run_tbl[i].rst;
      @(posedge clk); #1;
      check($sformatf("run[%0d]", i), 1'b1);
    end

    // advance into S2, then reset asynchronously mid-cycle
    push_exp(S2, 1'b0, S0);
    @(posedge clk); #1;
    check("pre_reset_s2", 1'b1);
    #2;
    reset = 1'b1;
    push_exp(S0, 1'b1, S1);
    #1;
    check("async_reset", 1'b1);
    push_exp(S0, 1'b1, S1);
    @(posedge clk); #1;
    check("reset_hold", 1'b1);
    #6;
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      push_exp(restart_tbl[i].st, restart_tbl[i].yv, restart_tbl[i].ns);
      @(posedge clk); #1;
      check($sformatf("restart[%0d]", i), 1'b1);
    end

    // illegal code: forced mid-cycle, released before the next edge
    #2;
    force dut.state = BAD;
    push_exp(BAD, 1'b0, S0);
    #1;
    check("illegal_code", 1'b0);
    release dut.state;
    push_exp(S0, 1'b1, S1);
    @(posedge clk); #1;
    check("recover_s0", 1'b1);
    push_exp(S1, 1'b0, S2);
    @(posedge clk); #1;
    check("recover_s1", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
